// File: rtl/calc_pkg.sv
// Shared constants for the 4-bit calculator: FSM state encodings, operator
// codes and display-select codes. No ports; imported by the calc blocks.
package calc_pkg;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_GET_A  = 3'd1;
    localparam state_t ST_GET_OP = 3'd2;
    localparam state_t ST_GET_B  = 3'd3;
    localparam state_t ST_EXEC   = 3'd4;
    localparam state_t ST_WAIT   = 3'd5;
    localparam state_t ST_SHOW   = 3'd6;
    localparam state_t ST_ERR    = 3'd7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] DISP_A   = 2'b00;
    localparam logic [1:0] DISP_B   = 2'b01;
    localparam logic [1:0] DISP_R   = 2'b10;
    localparam logic [1:0] DISP_ERR = 2'b11;

    localparam int CNT_W = 8;
endpackage

// File: rtl/calc_timeout_ctr.sv
// 8-bit saturating wait counter for the ALU handshake.
// Ports:
//   clck    in  clock, rising edge
//   reste   in  async active-low reset
//   clear   in  synchronous clear to 0
//   en      in  count this cycle (saturates at 255)
//   limit   in  cycle budget
//   expired out this cycle's increment brings the count to limit
module calc_timeout_ctr
    import calc_pkg::*;
(
    input  logic             clck,
    input  logic             reste,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clck or negedge reste) begin
        if (!reste) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Looks one increment ahead so the FSM leaves WAIT on the edge where the
    // count would reach the limit: exactly 'limit' cycles spent in WAIT.
    assign expired = en && (({1'b0, r_cnt} + 9'd1) >= {1'b0, limit});
endmodule

// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: drives the A/B/OP/RESULT load enables, runs one
// ALU start/done handshake with a timeout, and selects the display source.
// Ports:
//   clck, reste            clock / async active-low reset
//   digit_vld, digit       keypad operand strobe + value (captured by datapath)
//   op_vld, op             operator strobe + code (captured by datapath)
//   eq_vld                 '=' strobe
//   clr                    synchronous clear level
//   alu_done, alu_err      ALU completion pulse + error qualifier
//   ld_a/ld_b/ld_op/ld_r   Mealy load enables
//   alu_start              one-cycle ALU start pulse
//   disp_sel, busy, err    Moore display/status outputs
//   state                  encoded FSM state
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clck,
    input  logic             reste,
    input  logic             digit_vld,
    input  logic [WIDTH-1:0] digit,
    input  logic             op_vld,
    input  logic [1:0]       op,
    input  logic             eq_vld,
    input  logic             clr,
    input  logic             alu_done,
    input  logic             alu_err,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_op,
    output logic             ld_r,
    output logic             alu_start,
    output logic [1:0]       disp_sel,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    state_t r_state;
    state_t w_next;
    logic   w_eq_win, w_op_win, w_dig_win;
    logic   w_cnt_clear, w_cnt_en, w_expired;
    logic   w_unused;

    // Operand/operator values go straight to the datapath registers.
    assign w_unused = ^{digit, op};

    // Strict priority clr > eq > op > digit: the top strobe present wins even
    // if the current state ignores it, and everything below it is dropped.
    assign w_eq_win  = !clr && eq_vld;
    assign w_op_win  = !clr && !eq_vld && op_vld;
    assign w_dig_win = !clr && !eq_vld && !op_vld && digit_vld;

    assign w_cnt_clear = clr || (r_state == ST_EXEC);
    assign w_cnt_en    = !clr && (r_state == ST_WAIT) && !alu_done;

    calc_timeout_ctr u_tmo (
        .clck    (clck),
        .reste   (reste),
        .clear   (w_cnt_clear),
        .en      (w_cnt_en),
        .limit   (LIMIT),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clck or negedge reste) begin
        if (!reste) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_dig_win) w_next = ST_GET_A;
                end
                ST_GET_A, ST_SHOW: begin
                    if (w_op_win)       w_next = ST_GET_OP;
                    else if (w_dig_win) w_next = ST_GET_A;
                end
                ST_GET_OP: begin
                    if (w_op_win)       w_next = ST_GET_OP;
                    else if (w_dig_win) w_next = ST_GET_B;
                end
                ST_GET_B: begin
                    if (w_eq_win)       w_next = ST_EXEC;
                    else if (w_dig_win) w_next = ST_GET_B;
                end
                ST_EXEC: w_next = ST_WAIT;
                ST_WAIT: begin
                    if (alu_done)       w_next = alu_err ? ST_ERR : ST_SHOW;
                    else if (w_expired) w_next = ST_ERR;
                end
                ST_ERR:  w_next = ST_ERR;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Output decode. Mealy outputs are gated by reste so they drop during reset
    // even while a strobe is still present.
    always_comb begin
        ld_a      = reste && w_dig_win &&
                    ((r_state == ST_IDLE) || (r_state == ST_GET_A) || (r_state == ST_SHOW));
        ld_b      = reste && w_dig_win &&
                    ((r_state == ST_GET_OP) || (r_state == ST_GET_B));
        ld_op     = reste && w_op_win &&
                    ((r_state == ST_GET_A) || (r_state == ST_GET_OP) || (r_state == ST_SHOW));
        ld_r      = reste && !clr && (r_state == ST_WAIT) && alu_done && !alu_err;
        alu_start = reste && !clr && (r_state == ST_EXEC);

        busy  = (r_state == ST_EXEC) || (r_state == ST_WAIT);
        err   = (r_state == ST_ERR);
        state = r_state;
        unique case (r_state)
            ST_GET_B:                   disp_sel = DISP_B;
            ST_EXEC, ST_WAIT, ST_SHOW:  disp_sel = DISP_R;
            ST_ERR:                     disp_sel = DISP_ERR;
            default:                    disp_sel = DISP_A;
        endcase
    end
endmodule

// File: tb/tb_calc_entry_sequencer.sv
module tb_calc_entry_sequencer;
    logic       clck = 1'b0;
    logic       reste;
    logic       digit_vld, op_vld, eq_vld, clr, alu_done, alu_err;
    logic [3:0] digit;
    logic [1:0] op;
    logic       ld_a, ld_b, ld_op, ld_r, alu_start, busy, err;
    logic [1:0] disp_sel;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    calc_entry_sequencer #(.WIDTH(4), .TIMEOUT_CYC(15)) dut (
        .clck(clck), .reste(reste),
        .digit_vld(digit_vld), .digit(digit),
        .op_vld(op_vld), .op(op), .eq_vld(eq_vld), .clr(clr),
        .alu_done(alu_done), .alu_err(alu_err),
        .ld_a(ld_a), .ld_b(ld_b), .ld_op(ld_op), .ld_r(ld_r),
        .alu_start(alu_start), .disp_sel(disp_sel),
        .busy(busy), .err(err), .state(state)
    );

    always #5 clck = ~clck;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed load vector {ld_a, ld_b, ld_op, ld_r, alu_start}
    function automatic logic [7:0] lds();
        return {3'b0, ld_a, ld_b, ld_op, ld_r, alu_start};
    endfunction

    // Advance one clock: inputs change 1 time unit after the rising edge,
    // then all strobes drop.
    task automatic step();
        @(posedge clck);
        #1;
        digit_vld = 0; op_vld = 0; eq_vld = 0; clr = 0; alu_done = 0; alu_err = 0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit = d; digit_vld = 1; #1;
    endtask

    task automatic press_op(input logic [1:0] o);
        op = o; op_vld = 1; #1;
    endtask

    initial begin
        reste = 0; digit_vld = 0; op_vld = 0; eq_vld = 0; clr = 0;
        alu_done = 0; alu_err = 0; digit = 0; op = 0;
        #12;
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_loads", lds(), 8'h00);
        chk("reset_status", {4'b0, disp_sel, busy, err}, 8'h00);
        reste = 1;
        idle(10);
        chk("idle_10", 8'(state), 8'd0);

        // 3 + 5 ADD
        press_digit(4'd3);
        chk("add_ld_a", lds(), 8'b10000);
        step(); chk("add_get_a", 8'(state), 8'd1);
        press_op(2'b00);
        chk("add_ld_op", lds(), 8'b00100);
        step(); chk("add_get_op", 8'(state), 8'd2);
        press_digit(4'd5);
        chk("add_ld_b", lds(), 8'b01000);
        step(); chk("add_get_b", 8'(state), 8'd3);
        chk("add_disp_b", 8'(disp_sel), 8'd1);
        eq_vld = 1; #1;
        chk("add_eq_noload", lds(), 8'h00);
        step(); chk("add_exec", 8'(state), 8'd4);
        chk("add_start", lds(), 8'b00001);
        chk("add_busy", 8'(busy), 8'd1);
        step(); chk("add_wait", 8'(state), 8'd5);
        chk("add_start_once", lds(), 8'h00);
        chk("add_disp_wait", 8'(disp_sel), 8'd2);
        idle(2);
        alu_done = 1; #1;
        chk("add_ld_r", lds(), 8'b00010);
        step(); chk("add_show", 8'(state), 8'd6);
        chk("add_disp_show", 8'(disp_sel), 8'd2);
        chk("add_notbusy", 8'(busy), 8'd0);

        // Overwrite A, ignored '=' in GET_A, then chaining from SHOW
        press_digit(4'd2);
        chk("ow_ld_a1", lds(), 8'b10000);
        step();
        press_digit(4'd7);
        chk("ow_ld_a2", lds(), 8'b10000);
        step(); chk("ow_state", 8'(state), 8'd1);
        eq_vld = 1; #1;
        chk("ign_eq_loads", lds(), 8'h00);
        step(); chk("ign_eq_state", 8'(state), 8'd1);
        press_op(2'b01); step();
        press_digit(4'd4); step();
        eq_vld = 1; step(); step();
        alu_done = 1; step();
        chk("chain_show", 8'(state), 8'd6);
        press_op(2'b10);
        chk("chain_ld", lds(), 8'b00100);
        step(); chk("chain_state", 8'(state), 8'd2);

        // ALU error; digit ignored in WAIT
        press_digit(4'd1); step();
        eq_vld = 1; step(); step();
        chk("err_in_wait", 8'(state), 8'd5);
        press_digit(4'd9);
        chk("ign_dig_wait_ld", lds(), 8'h00);
        step(); chk("ign_dig_wait_st", 8'(state), 8'd5);
        alu_done = 1; alu_err = 1; #1;
        chk("err_no_ld_r", lds(), 8'h00);
        step(); chk("err_state", 8'(state), 8'd7);
        chk("err_flags", {4'b0, disp_sel, busy, err}, 8'b1101);
        press_digit(4'd1); step();
        chk("err_sticky", 8'(state), 8'd7);
        clr = 1; #1;
        chk("err_clr_loads", lds(), 8'h00);
        step(); chk("err_clr_idle", 8'(state), 8'd0);

        // Timeout: ERR exactly 15 cycles after entering WAIT
        press_digit(4'd1); step();
        press_op(2'b11); step();
        press_digit(4'd0); step();
        eq_vld = 1; step(); step();
        chk("tmo_wait", 8'(state), 8'd5);
        idle(14);
        chk("tmo_still_wait", 8'(state), 8'd5);
        step();
        chk("tmo_err", 8'(state), 8'd7);
        chk("tmo_err_flag", 8'(err), 8'd1);
        clr = 1; step();

        // Priority: eq beats op and digit in GET_B
        press_digit(4'd6); step();
        press_op(2'b00); step();
        press_digit(4'd2); step();
        eq_vld = 1; op_vld = 1; digit_vld = 1; #1;
        chk("prio_loads", lds(), 8'h00);
        step(); chk("prio_exec", 8'(state), 8'd4);
        step();
        // clr in WAIT, then a stale alu_done in IDLE
        clr = 1; #1;
        chk("clr_wait_ld", lds(), 8'h00);
        step(); chk("clr_wait_idle", 8'(state), 8'd0);
        alu_done = 1; #1;
        chk("stale_done_ld_r", 8'(ld_r), 8'd0);
        step(); chk("stale_done_idle", 8'(state), 8'd0);

        // clr together with eq in GET_B
        press_digit(4'd1); step();
        press_op(2'b00); step();
        press_digit(4'd1); step();
        clr = 1; eq_vld = 1; #1;
        chk("clr_eq_loads", lds(), 8'h00);
        step(); chk("clr_eq_idle", 8'(state), 8'd0);

        // Async reset mid-WAIT with alu_done still high
        press_digit(4'd1); step();
        press_op(2'b00); step();
        press_digit(4'd1); step();
        eq_vld = 1; step(); step();
        chk("rst_pre_wait", 8'(state), 8'd5);
        alu_done = 1; #1;
        reste = 0; #1;
        chk("rst_async_state", 8'(state), 8'd0);
        chk("rst_async_loads", lds(), 8'h00);
        chk("rst_async_status", {4'b0, disp_sel, busy, err}, 8'h00);
        step();
        reste = 1;
        idle(10);
        chk("rst_idle_10", 8'(state), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
